// File: rtl/sc_spi_slv_if.sv
// sc_spi_slv_if: bundles the SPI target's config, word exchange, status and pin signals.
// Latency: none, wiring only.
// Backpressure: carries TXVALID/TXREADY for the TX holding buffer; RX side is a strobe plus RXACK.
// Signals: CPOL/CPHA/DWIDTH config; TXDATA/TXVALID/TXREADY; RXDATA/RXVALID/RXACK;
//          SLVBUSY/TXUNDER/RXOVER/ERRCLR status; CSB/SCLK/MOSI/MISO/MISOEN pins.
// Modports: slave = engine view, master = register/FIFO layer plus external SPI master view.
interface sc_spi_slv_if;
   logic        CPOL;
   logic        CPHA;
   logic [4:0]  DWIDTH;
   logic [31:0] TXDATA;
   logic        TXVALID;
   logic        TXREADY;
   logic [31:0] RXDATA;
   logic        RXVALID;
   logic        RXACK;
   logic        SLVBUSY;
   logic        TXUNDER;
   logic        RXOVER;
   logic        ERRCLR;
   logic        CSB;
   logic        SCLK;
   logic        MOSI;
   logic        MISO;
   logic        MISOEN;

   modport slave (
      input  CPOL, CPHA, DWIDTH, TXDATA, TXVALID, RXACK, ERRCLR, CSB, SCLK, MOSI,
      output TXREADY, RXDATA, RXVALID, SLVBUSY, TXUNDER, RXOVER, MISO, MISOEN
   );

   modport master (
      output CPOL, CPHA, DWIDTH, TXDATA, TXVALID, RXACK, ERRCLR, CSB, SCLK, MOSI,
      input  TXREADY, RXDATA, RXVALID, SLVBUSY, TXUNDER, RXOVER, MISO, MISOEN
   );
endinterface

// File: rtl/sc_spi_slv.sv
// sc_spi_slv: SPI target engine, pins oversampled on SPICLK, 8-32 bit words MSB-first, CPOL/CPHA modes 0-3.
// Latency: pin edge -> MISO/MISOEN/RX shift 4 SPICLK; last sample edge -> RXVALID 4 SPICLK after the pin edge.
// Backpressure: one-word TX holding buffer (TXVALID/TXREADY); RX is a strobe, an unacked overwrite flags RXOVER.
// Ports: SPICLK clock, SYSRSTB async active-low reset, bus (sc_spi_slv_if.slave) for everything else.
// Option: define SC_SPI_SLV_ERRDET_EN to enable TXUNDER/RXOVER/ERRCLR and the RX pending flag;
//         when undefined the error outputs are tied low and RXACK/ERRCLR are ignored.
module sc_spi_slv (
   input logic          SPICLK,
   input logic          SYSRSTB,
   sc_spi_slv_if.slave  bus
);
   typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

   // 2-flop synchronizers plus one history flop per pin
   logic r_csb_s1, r_csb_s2, r_csb_h;
   logic r_sclk_s1, r_sclk_s2, r_sclk_h;
   logic r_mosi_s1, r_mosi_s2, r_mosi_h;
   // registered edge pulses; these give the 3-cycle pin-to-detect latency
   logic r_csb_fall, r_csb_rise, r_sclk_rise, r_sclk_fall;

   state_t      r_state;
   logic        r_cpol, r_cpha;
   logic [4:0]  r_dw, r_bc;
   logic [31:0] r_tx_sh, r_rx_sh, r_rxdata, r_tx_buf;
   logic        r_miso, r_misoen, r_busy, r_rxvalid, r_tx_rdy;

   logic [4:0]  w_dw_in;
   logic        w_lead, w_trail, w_sample, w_drive;
   logic        w_start, w_done, w_load, w_underrun, w_tx_wr;
   logic [31:0] w_ld_word, w_rx_next, w_rx_mask;

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         {r_csb_s1, r_csb_s2, r_csb_h}    <= 3'b111;
         {r_sclk_s1, r_sclk_s2, r_sclk_h} <= 3'b000;
         {r_mosi_s1, r_mosi_s2, r_mosi_h} <= 3'b000;
         {r_csb_fall, r_csb_rise, r_sclk_rise, r_sclk_fall} <= 4'b0000;
      end else begin
         r_csb_s1    <= bus.CSB;
         r_csb_s2    <= r_csb_s1;
         r_csb_h     <= r_csb_s2;
         r_sclk_s1   <= bus.SCLK;
         r_sclk_s2   <= r_sclk_s1;
         r_sclk_h    <= r_sclk_s2;
         r_mosi_s1   <= bus.MOSI;
         r_mosi_s2   <= r_mosi_s1;
         r_mosi_h    <= r_mosi_s2;
         r_csb_fall  <= r_csb_h & ~r_csb_s2;
         r_csb_rise  <= ~r_csb_h & r_csb_s2;
         r_sclk_rise <= ~r_sclk_h & r_sclk_s2;
         r_sclk_fall <= r_sclk_h & ~r_sclk_s2;
      end
   end

   assign w_dw_in    = (bus.DWIDTH < 5'd7) ? 5'd7 : bus.DWIDTH;
   // edges are classified with the mode latched at word start
   assign w_lead     = r_cpol ? r_sclk_fall : r_sclk_rise;
   assign w_trail    = r_cpol ? r_sclk_rise : r_sclk_fall;
   assign w_sample   = r_cpha ? w_trail : w_lead;
   assign w_drive    = r_cpha ? w_lead  : w_trail;
   assign w_start    = (r_state == ST_IDLE) & r_csb_fall;
   assign w_done     = (r_state == ST_ACTIVE) & ~r_csb_rise & w_sample & (r_bc == r_dw);
   assign w_load     = w_start | w_done;
   assign w_underrun = w_load & r_tx_rdy;
   assign w_ld_word  = r_tx_rdy ? 32'h0 : r_tx_buf;
   // the MOSI history flop has the same pipeline age as the SCLK edge pulse
   assign w_rx_next  = {r_rx_sh[30:0], r_mosi_h};
   assign w_rx_mask  = 32'hFFFF_FFFF >> (5'd31 - r_dw);
   assign w_tx_wr    = bus.TXVALID & r_tx_rdy;

   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         r_state   <= ST_IDLE;
         r_cpol    <= 1'b0;
         r_cpha    <= 1'b0;
         r_dw      <= 5'd7;
         r_bc      <= 5'd0;
         r_tx_sh   <= 32'h0;
         r_rx_sh   <= 32'h0;
         r_rxdata  <= 32'h0;
         r_tx_buf  <= 32'h0;
         r_tx_rdy  <= 1'b1;
         r_miso    <= 1'b0;
         r_misoen  <= 1'b0;
         r_busy    <= 1'b0;
         r_rxvalid <= 1'b0;
      end else begin
         r_rxvalid <= 1'b0;
         // a write can only land in an empty buffer, so it overrides a same-cycle (underrun) load
         if (w_load)  r_tx_rdy <= 1'b1;
         if (w_tx_wr) begin
            r_tx_buf <= bus.TXDATA;
            r_tx_rdy <= 1'b0;
         end
         case (r_state)
            ST_IDLE: begin
               if (w_start) begin
                  r_state  <= ST_ACTIVE;
                  r_busy   <= 1'b1;
                  r_misoen <= 1'b1;
                  r_cpol   <= bus.CPOL;
                  r_cpha   <= bus.CPHA;
                  r_dw     <= w_dw_in;
                  r_bc     <= 5'd0;
                  if (bus.CPHA) begin
                     r_tx_sh <= w_ld_word;
                  end else begin
                     // CPHA=0 presents the MSB now, so the shifter starts one bit ahead
                     r_miso  <= w_ld_word[w_dw_in];
                     r_tx_sh <= w_ld_word << 1;
                  end
               end
            end
            ST_ACTIVE: begin
               if (r_csb_rise) begin
                  r_state  <= ST_IDLE;
                  r_busy   <= 1'b0;
                  r_misoen <= 1'b0;
                  r_miso   <= 1'b0;
                  r_bc     <= 5'd0;
               end else begin
                  if (w_drive) begin
                     r_miso  <= r_tx_sh[r_dw];
                     r_tx_sh <= r_tx_sh << 1;
                  end
                  if (w_sample) begin
                     r_rx_sh <= w_rx_next;
                     if (r_bc == r_dw) begin
                        // word complete: next drive edge presents the reloaded word's MSB
                        r_bc      <= 5'd0;
                        r_rxdata  <= w_rx_next & w_rx_mask;
                        r_rxvalid <= 1'b1;
                        r_tx_sh   <= w_ld_word;
                     end else begin
                        r_bc <= r_bc + 5'd1;
                     end
                  end
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

`ifdef SC_SPI_SLV_ERRDET_EN
   logic r_rx_pend, r_txunder, r_rxover;

   // set terms take priority over RXACK/ERRCLR
   always_ff @(posedge SPICLK or negedge SYSRSTB) begin
      if (!SYSRSTB) begin
         r_rx_pend <= 1'b0;
         r_txunder <= 1'b0;
         r_rxover  <= 1'b0;
      end else begin
         if (r_rxvalid)           r_rx_pend <= 1'b1;
         else if (bus.RXACK)      r_rx_pend <= 1'b0;
         if (w_underrun)          r_txunder <= 1'b1;
         else if (bus.ERRCLR)     r_txunder <= 1'b0;
         if (w_done & r_rx_pend)  r_rxover  <= 1'b1;
         else if (bus.ERRCLR)     r_rxover  <= 1'b0;
      end
   end

   assign bus.TXUNDER = r_txunder;
   assign bus.RXOVER  = r_rxover;
`else
   logic w_unused;
   assign w_unused    = ^{bus.RXACK, bus.ERRCLR, w_underrun};
   assign bus.TXUNDER = 1'b0;
   assign bus.RXOVER  = 1'b0;
`endif

   assign bus.TXREADY = r_tx_rdy;
   assign bus.RXDATA  = r_rxdata;
   assign bus.RXVALID = r_rxvalid;
   assign bus.SLVBUSY = r_busy;
   assign bus.MISO    = r_miso;
   assign bus.MISOEN  = r_misoen;
endmodule

// File: tb/tb_sc_spi_slv.sv
// tb_sc_spi_slv: drives sc_spi_slv as an external SPI master plus a TX/RX word user.
// Latency: master half-period is 8 SPICLK; MISO is read at the master's own sample edge.
// Backpressure: TX words wait on TXREADY with a cycle budget; received words checked from a queue.
`timescale 1ns/1ps
module tb_sc_spi_slv;
   localparam int H = 8;
`ifdef SC_SPI_SLV_ERRDET_EN
   localparam bit ERRDET = 1'b1;
`else
   localparam bit ERRDET = 1'b0;
`endif

   logic SPICLK = 1'b0;
   logic SYSRSTB;
   sc_spi_slv_if bus ();

   sc_spi_slv dut (.SPICLK(SPICLK), .SYSRSTB(SYSRSTB), .bus(bus));

   always #5 SPICLK = ~SPICLK;

   int          n_cmp = 0;
   int          n_err = 0;
   int          n_rxv = 0;
   logic [31:0] q_rx[$];
   logic [31:0] q_tx[$];
   logic [31:0] m_mosi[4];
   logic [31:0] m_miso[4];
   logic [31:0] mon_exp;

   // RX scoreboard: every RXVALID pulse pops one expected word
   always @(negedge SPICLK) begin
      if (SYSRSTB === 1'b1 && bus.RXVALID === 1'b1) begin
         n_rxv++;
         n_cmp++;
         if (q_rx.size() == 0) begin
            n_err++;
            $display("FAIL rx_unexpected: RXVALID with RXDATA=%h, no word expected", bus.RXDATA);
         end else begin
            mon_exp = q_rx.pop_front();
            if (bus.RXDATA !== mon_exp) begin
               n_err++;
               $display("FAIL rx_data: got %h, need %h", bus.RXDATA, mon_exp);
            end
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge SPICLK);
      #1;
   endtask

   task automatic tx_write(input logic [31:0] d);
      int t;
      t = 0;
      while (bus.TXREADY !== 1'b1 && t < 2000) begin
         cyc(1);
         t++;
      end
      if (bus.TXREADY !== 1'b1) begin
         n_cmp++;
         n_err++;
         $display("FAIL tx_ready_timeout: TXREADY=%b after %0d cycles, need 1", bus.TXREADY, t);
      end else begin
         bus.TXDATA  = d;
         bus.TXVALID = 1'b1;
         cyc(1);
         bus.TXVALID = 1'b0;
      end
   endtask

   task automatic ack_clear();
      bus.RXACK  = 1'b1;
      bus.ERRCLR = 1'b1;
      cyc(1);
      bus.RXACK  = 1'b0;
      bus.ERRCLR = 1'b0;
   endtask

   // nb bits of each of nw words, MSB first; keep leaves CSB low at the end
   task automatic spi_xfer(input int nw, input int nb, input logic [4:0] dw,
                           input bit cpol, input bit cpha, input bit keep);
      bus.CPOL   = cpol;
      bus.CPHA   = cpha;
      bus.DWIDTH = dw;
      bus.SCLK   = cpol;
      cyc(H);
      bus.CSB = 1'b0;
      cyc(H);
      for (int w = 0; w < nw; w++) begin
         m_miso[w] = 32'h0;
         for (int b = 0; b < nb; b++) begin
            int bi;
            bi = int'(dw) - b;
            if (!cpha) begin
               bus.MOSI = m_mosi[w][bi];
               cyc(H);
               m_miso[w][bi] = bus.MISO;
               bus.SCLK = ~cpol;
               cyc(H);
               bus.SCLK = cpol;
            end else begin
               bus.SCLK = ~cpol;
               bus.MOSI = m_mosi[w][bi];
               cyc(H);
               m_miso[w][bi] = bus.MISO;
               bus.SCLK = cpol;
               cyc(H);
            end
         end
      end
      cyc(H);
      if (!keep) begin
         bus.CSB  = 1'b1;
         bus.MOSI = 1'b0;
         cyc(H);
      end
   endtask

   task automatic test_reset();
      SYSRSTB = 1'b0;
      cyc(3);
      n_cmp++;
      if ({bus.TXREADY, bus.RXVALID, bus.SLVBUSY, bus.TXUNDER, bus.RXOVER, bus.MISO, bus.MISOEN} !== 7'b1000000) begin
         n_err++;
         $display("FAIL reset_flags: got %b, need 1000000", {bus.TXREADY, bus.RXVALID, bus.SLVBUSY, bus.TXUNDER, bus.RXOVER, bus.MISO, bus.MISOEN});
      end
      n_cmp++;
      if (bus.RXDATA !== 32'h0) begin
         n_err++;
         $display("FAIL reset_rxdata: got %h, need 0", bus.RXDATA);
      end
      SYSRSTB = 1'b1;
      cyc(6);
      n_cmp++;
      if ({bus.TXREADY, bus.SLVBUSY, bus.MISOEN} !== 3'b100) begin
         n_err++;
         $display("FAIL idle_after_reset: got %b, need 100", {bus.TXREADY, bus.SLVBUSY, bus.MISOEN});
      end
   endtask

   task automatic test_latency();
      int v0;
      v0 = n_rxv;
      tx_write(32'h80);
      bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.DWIDTH = 5'd7; bus.SCLK = 1'b0;
      cyc(2);
      bus.CSB = 1'b0;
      cyc(3);
      n_cmp++;
      if ({bus.SLVBUSY, bus.MISOEN} !== 2'b00) begin
         n_err++;
         $display("FAIL csb_fall_3clk: busy/en got %b, need 00", {bus.SLVBUSY, bus.MISOEN});
      end
      cyc(1);
      n_cmp++;
      if ({bus.SLVBUSY, bus.MISOEN, bus.MISO, bus.TXREADY} !== 4'b1111) begin
         n_err++;
         $display("FAIL csb_fall_4clk: busy/en/miso/rdy got %b, need 1111", {bus.SLVBUSY, bus.MISOEN, bus.MISO, bus.TXREADY});
      end
      bus.CSB = 1'b1;
      cyc(3);
      n_cmp++;
      if (bus.SLVBUSY !== 1'b1) begin
         n_err++;
         $display("FAIL csb_rise_3clk: busy got %b, need 1", bus.SLVBUSY);
      end
      cyc(1);
      n_cmp++;
      if ({bus.SLVBUSY, bus.MISOEN, bus.MISO} !== 3'b000) begin
         n_err++;
         $display("FAIL csb_rise_4clk: busy/en/miso got %b, need 000", {bus.SLVBUSY, bus.MISOEN, bus.MISO});
      end
      n_cmp++;
      if (n_rxv !== v0) begin
         n_err++;
         $display("FAIL latency_no_rx: rxvalid pulses got %0d, need %0d", n_rxv, v0);
      end
   endtask

   task automatic test_mode0();
      int v0;
      logic [31:0] e;
      ack_clear();
      v0 = n_rxv;
      tx_write(32'hA5);
      q_tx.push_back(32'hA5);
      m_mosi[0] = 32'h3C;
      q_rx.push_back(32'h3C);
      spi_xfer(1, 8, 5'd7, 1'b0, 1'b0, 1'b0);
      e = q_tx.pop_front();
      n_cmp++;
      if (m_miso[0] !== e) begin
         n_err++;
         $display("FAIL mode0_miso: got %h, need %h", m_miso[0], e);
      end
      n_cmp++;
      if (n_rxv - v0 !== 1) begin
         n_err++;
         $display("FAIL mode0_rxvalid_count: got %0d, need 1", n_rxv - v0);
      end
      n_cmp++;
      if (bus.TXREADY !== 1'b1) begin
         n_err++;
         $display("FAIL mode0_txready: got %b, need 1", bus.TXREADY);
      end
   endtask

   task automatic test_modes();
      for (int m = 1; m < 4; m++) begin
         int v0;
         logic [31:0] e;
         ack_clear();
         v0 = n_rxv;
         tx_write(32'hDEADBEEF);
         q_tx.push_back(32'hDEADBEEF);
         m_mosi[0] = 32'h12345678;
         q_rx.push_back(32'h12345678);
         spi_xfer(1, 32, 5'd31, m[1], m[0], 1'b0);
         e = q_tx.pop_front();
         n_cmp++;
         if (m_miso[0] !== e) begin
            n_err++;
            $display("FAIL mode%0d_miso: got %h, need %h", m, m_miso[0], e);
         end
         n_cmp++;
         if (n_rxv - v0 !== 1) begin
            n_err++;
            $display("FAIL mode%0d_rxvalid_count: got %0d, need 1", m, n_rxv - v0);
         end
      end
   endtask

   task automatic test_back_to_back();
      int v0;
      logic [31:0] e;
      ack_clear();
      v0 = n_rxv;
      tx_write(32'h1111);
      n_cmp++;
      if (bus.TXUNDER !== 1'b0) begin
         n_err++;
         $display("FAIL b2b_txunder_clear: got %b, need 0", bus.TXUNDER);
      end
      q_tx.push_back(32'h1111); q_tx.push_back(32'h2222); q_tx.push_back(32'h0000);
      m_mosi[0] = 32'hABCD; m_mosi[1] = 32'h0F0F; m_mosi[2] = 32'h8001;
      q_rx.push_back(32'hABCD); q_rx.push_back(32'h0F0F); q_rx.push_back(32'h8001);
      fork
         spi_xfer(3, 16, 5'd15, 1'b0, 1'b0, 1'b0);
         tx_write(32'h2222);
      join
      for (int w = 0; w < 3; w++) begin
         e = q_tx.pop_front();
         n_cmp++;
         if (m_miso[w] !== e) begin
            n_err++;
            $display("FAIL b2b_miso_word%0d: got %h, need %h", w, m_miso[w], e);
         end
      end
      n_cmp++;
      if (n_rxv - v0 !== 3) begin
         n_err++;
         $display("FAIL b2b_rxvalid_count: got %0d, need 3", n_rxv - v0);
      end
      n_cmp++;
      if (bus.TXUNDER !== ERRDET) begin
         n_err++;
         $display("FAIL b2b_txunder: got %b, need %b", bus.TXUNDER, ERRDET);
      end
   endtask

   task automatic test_overrun();
      ack_clear();
      n_cmp++;
      if (bus.RXOVER !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_clear_before: got %b, need 0", bus.RXOVER);
      end
      m_mosi[0] = 32'h11; m_mosi[1] = 32'h22;
      q_rx.push_back(32'h11); q_rx.push_back(32'h22);
      spi_xfer(2, 8, 5'd7, 1'b1, 1'b1, 1'b0);
      n_cmp++;
      if (bus.RXOVER !== ERRDET) begin
         n_err++;
         $display("FAIL ovr_rxover: got %b, need %b", bus.RXOVER, ERRDET);
      end
      n_cmp++;
      if (bus.RXDATA !== 32'h22) begin
         n_err++;
         $display("FAIL ovr_rxdata: got %h, need 00000022", bus.RXDATA);
      end
      n_cmp++;
      if (m_miso[0] !== 32'h0 || m_miso[1] !== 32'h0) begin
         n_err++;
         $display("FAIL ovr_underrun_zeros: got %h/%h, need 0/0", m_miso[0], m_miso[1]);
      end
      bus.ERRCLR = 1'b1;
      cyc(1);
      bus.ERRCLR = 1'b0;
      cyc(1);
      n_cmp++;
      if (bus.RXOVER !== 1'b0) begin
         n_err++;
         $display("FAIL ovr_errclr: got %b, need 0", bus.RXOVER);
      end
   endtask

   task automatic test_abort();
      int v0;
      logic [31:0] e;
      ack_clear();
      v0 = n_rxv;
      tx_write(32'hFF);
      m_mosi[0] = 32'hFF;
      spi_xfer(1, 5, 5'd7, 1'b0, 1'b0, 1'b1);
      bus.CSB = 1'b1;
      cyc(3);
      n_cmp++;
      if (bus.MISOEN !== 1'b1) begin
         n_err++;
         $display("FAIL abort_misoen_3clk: got %b, need 1", bus.MISOEN);
      end
      cyc(1);
      n_cmp++;
      if ({bus.MISOEN, bus.MISO, bus.SLVBUSY} !== 3'b000) begin
         n_err++;
         $display("FAIL abort_4clk: en/miso/busy got %b, need 000", {bus.MISOEN, bus.MISO, bus.SLVBUSY});
      end
      cyc(H);
      n_cmp++;
      if (n_rxv !== v0) begin
         n_err++;
         $display("FAIL abort_no_rx: pulses got %0d, need %0d", n_rxv, v0);
      end
      tx_write(32'h5A);
      q_tx.push_back(32'h5A);
      m_mosi[0] = 32'h81;
      q_rx.push_back(32'h81);
      spi_xfer(1, 8, 5'd7, 1'b0, 1'b0, 1'b0);
      e = q_tx.pop_front();
      n_cmp++;
      if (m_miso[0] !== e) begin
         n_err++;
         $display("FAIL abort_next_miso: got %h, need %h", m_miso[0], e);
      end
      n_cmp++;
      if (n_rxv - v0 !== 1) begin
         n_err++;
         $display("FAIL abort_next_count: got %0d, need 1", n_rxv - v0);
      end
   endtask

   task automatic test_reset_midword();
      int v0;
      logic [31:0] e;
      tx_write(32'h77);
      bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.DWIDTH = 5'd7; bus.SCLK = 1'b0;
      cyc(2);
      bus.CSB = 1'b0;
      cyc(H);
      for (int i = 0; i < 3; i++) begin
         bus.MOSI = 1'b1;
         cyc(H);
         bus.SCLK = 1'b1;
         cyc(H);
         bus.SCLK = 1'b0;
      end
      cyc(2);
      n_cmp++;
      if (bus.SLVBUSY !== 1'b1) begin
         n_err++;
         $display("FAIL rstmid_busy_before: got %b, need 1", bus.SLVBUSY);
      end
      SYSRSTB = 1'b0;
      #1;
      n_cmp++;
      if ({bus.TXREADY, bus.RXVALID, bus.SLVBUSY, bus.TXUNDER, bus.RXOVER, bus.MISO, bus.MISOEN} !== 7'b1000000) begin
         n_err++;
         $display("FAIL rstmid_flags: got %b, need 1000000", {bus.TXREADY, bus.RXVALID, bus.SLVBUSY, bus.TXUNDER, bus.RXOVER, bus.MISO, bus.MISOEN});
      end
      n_cmp++;
      if (bus.RXDATA !== 32'h0) begin
         n_err++;
         $display("FAIL rstmid_rxdata: got %h, need 0", bus.RXDATA);
      end
      bus.CSB = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
      cyc(3);
      SYSRSTB = 1'b1;
      cyc(4);
      v0 = n_rxv;
      tx_write(32'hC3);
      q_tx.push_back(32'hC3);
      m_mosi[0] = 32'h96;
      q_rx.push_back(32'h96);
      spi_xfer(1, 8, 5'd7, 1'b0, 1'b0, 1'b0);
      e = q_tx.pop_front();
      n_cmp++;
      if (m_miso[0] !== e) begin
         n_err++;
         $display("FAIL rstmid_after_miso: got %h, need %h", m_miso[0], e);
      end
      n_cmp++;
      if (n_rxv - v0 !== 1) begin
         n_err++;
         $display("FAIL rstmid_after_count: got %0d, need 1", n_rxv - v0);
      end
   endtask

   initial begin
      bus.CSB = 1'b1; bus.SCLK = 1'b0; bus.MOSI = 1'b0;
      bus.CPOL = 1'b0; bus.CPHA = 1'b0; bus.DWIDTH = 5'd7;
      bus.TXDATA = 32'h0; bus.TXVALID = 1'b0; bus.RXACK = 1'b0; bus.ERRCLR = 1'b0;
      SYSRSTB = 1'b0;
      test_reset();
      test_latency();
      test_mode0();
      test_modes();
      test_back_to_back();
      test_overrun();
      test_abort();
      test_reset_midword();
      n_cmp++;
      if (q_rx.size() != 0) begin
         n_err++;
         $display("FAIL rx_leftover: %0d expected words never received", q_rx.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation exceeded 2 ms");
      $fatal(1, "watchdog");
   end
endmodule
